spi_baud_generator: RTL

SPI serial-clock and strobe generator for the SPI master. It divides PCLK by a programmable baud divisor to produce `sclk`. It also produces the single-cycle strobes that the downstream shift register uses to launch MOSI bits (`flags_low`/`flags_high`) and sample MISO bits (`flag_low`/`flag_high`). It sits between the SPI control/register block, which supplies `sppr`, `spr`, `cpol`, mode and `ss`, and the shift register plus the external SCLK pin.

---
 rtl/spi_baud_generator_if.sv | 25 ++
 rtl/spi_baud_generator.sv | 47 ++++
 2 files changed

// File: rtl/spi_baud_generator_if.sv
// spi_baud_generator_if: control inputs and SCLK/strobe outputs between the SPI register block and the baud generator
// master: drives spi_mode, spiswai, ss, cpol, sppr, spr; observes sclk, strobes, baudratedivisor
// slave : the baud generator itself
interface spi_baud_generator_if;
    logic [1:0]  spi_mode;
    logic        spiswai;
    logic        ss;
    logic        cpol;
    logic [2:0]  sppr;
    logic [2:0]  spr;
    logic        sclk;
    logic        flag_low;
    logic        flag_high;
    logic        flags_low;
    logic        flags_high;
    logic [11:0] baudratedivisor;
    modport master (
        output spi_mode, spiswai, ss, cpol, sppr, spr,
        input  sclk, flag_low, flag_high, flags_low, flags_high, baudratedivisor
    );
    modport slave (
        input  spi_mode, spiswai, ss, cpol, sppr, spr,
        output sclk, flag_low, flag_high, flags_low, flags_high, baudratedivisor
    );
endinterface

// File: rtl/spi_baud_generator.sv
// spi_baud_generator: divides PCLK into SCLK and emits one-cycle launch (flags_*) and sample (flag_*) strobes
// PCLK/PRESET: clock and synchronous active-high reset
// bus: control inputs (mode, ss, cpol, sppr, spr) in; sclk, strobes, baudratedivisor out
module spi_baud_generator (
    input logic PCLK,
    input logic PRESET,
    spi_baud_generator_if.slave bus
);
    logic [11:0] half;
    logic [11:0] last;
    logic [11:0] term;
    logic [10:0] count;
    logic        sclk_q;
    logic        active;
    logic        at_last;
    logic        at_term;
    always_comb begin
        half    = ({9'd0, bus.sppr} + 12'd1) << bus.spr;
        last    = half - 12'd1;
        // with a one-cycle half period the launch strobe coincides with the sample strobe
        term    = (half == 12'd1) ? 12'd0 : half - 12'd2;
        active  = !PRESET && !bus.ss && (bus.spi_mode == 2'b00 || (bus.spi_mode == 2'b01 && !bus.spiswai));
        at_last = {1'b0, count} == last;
        at_term = {1'b0, count} == term;
    end
    // >= lets a divisor shrink mid-transfer toggle at once instead of wrapping the counter
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            count  <= '0;
            sclk_q <= 1'b0;
        end else if (!active) begin
            count  <= '0;
            sclk_q <= bus.cpol;
        end else if ({1'b0, count} >= last) begin
            count  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            count  <= count + 11'd1;
        end
    end
    assign bus.sclk            = sclk_q;
    assign bus.flag_low        = active && !sclk_q && at_last;
    assign bus.flag_high       = active &&  sclk_q && at_last;
    assign bus.flags_low       = active && !sclk_q && at_term;
    assign bus.flags_high      = active &&  sclk_q && at_term;
    assign bus.baudratedivisor = half << 1;
endmodule
